// File: rtl/uart_pkg.sv
// Shared UART constants: frame-state encoding and frame geometry, used by
// both the receiver and the transmitter so the two always agree.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned IDX_W     = $clog2(DATA_BITS);

endpackage

// File: rtl/fifo_sync.sv
// Synchronous FIFO with registered full/empty flags.
// Ports: clk, rst (sync, active-high), wr/din (push), rd (pop),
//        dout (head entry, valid while !empty), full, empty.
// Pushes while full and pops while empty are ignored; a push and a pop on
// the same edge leave the occupancy unchanged.
module fifo_sync #(
    parameter int unsigned width = 8,
    parameter int unsigned depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [width-1:0] din,
    input  logic             rd,
    output logic [width-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(depth);
    localparam int unsigned CW = AW + 1;

    logic [width-1:0] mem_q [depth];
    logic [width-1:0] mem_d [depth];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             wr_ok, rd_ok;

    // Next-state: pointers wrap naturally because depth is a power of two.
    always_comb begin
        wr_ok    = wr & ~full_q;
        rd_ok    = rd & ~empty_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(wr_ok) - CW'(rd_ok);
        full_d  = (count_d == CW'(depth));
        empty_d = (count_d == '0);
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8n1, with a transmit FIFO.
// Ports: clk (o x baud), rst (sync, active-high), in/clk_in (byte + write
//        strobe), out (serial line, idle high), full/empty (FIFO flags),
//        busy (frame in progress). All outputs are registered.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned o     = 4,
    parameter int unsigned depth = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in,
    input  logic       clk_in,
    output logic       out,
    output logic       full,
    output logic       empty,
    output logic       busy
);

    localparam int unsigned CW = $clog2(o);

    uart_state_e          state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 out_q, out_d;
    logic                 busy_q, busy_d;
    logic                 pop_c;
    logic [DATA_BITS-1:0] fifo_dout;
    logic                 last_tick;

    fifo_sync #(
        .width (DATA_BITS),
        .depth (depth)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (clk_in),
        .din   (in),
        .rd    (pop_c),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty)
    );

    // Next-state and line level. The shift register always presents the
    // current data bit in bit 0, so the next bit is shift_q[1].
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        out_d     = out_q;
        pop_c     = 1'b0;
        last_tick = (cnt_q == CW'(o - 1));

        unique case (state_q)
            IDLE: begin
                out_d = 1'b1;
                if (!empty) begin
                    pop_c   = 1'b1;
                    shift_d = fifo_dout;
                    cnt_d   = '0;
                    state_d = START;
                    out_d   = 1'b0;
                end
            end
            START: begin
                cnt_d = cnt_q + CW'(1);
                if (last_tick) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    out_d   = shift_q[0];
                end
            end
            DATA: begin
                cnt_d = cnt_q + CW'(1);
                if (last_tick) begin
                    cnt_d = '0;
                    if (bit_q == IDX_W'(DATA_BITS - 1)) begin
                        state_d = STOP;
                        out_d   = 1'b1;
                    end else begin
                        bit_d   = bit_q + IDX_W'(1);
                        shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                        out_d   = shift_q[1];
                    end
                end
            end
            STOP: begin
                cnt_d = cnt_q + CW'(1);
                if (last_tick) begin
                    cnt_d = '0;
                    // Back-to-back frames: reload straight into START.
                    if (!empty) begin
                        pop_c   = 1'b1;
                        shift_d = fifo_dout;
                        state_d = START;
                        out_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                        out_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                out_d   = 1'b1;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // Serialiser state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            out_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
        end
    end

    assign out  = out_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: an o=4 and an o=5 instance share one stimulus stream.
// A frame-position model (queue + offset into a 10*o-cycle frame) predicts
// every output after each edge; directed sequences add literal expectations.
module tb_uart_tx;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_in;
    logic [7:0] in;
    logic       out4, full4, empty4, busy4;
    logic       out5, full5, empty5, busy5;

    always #5 clk = ~clk;

    uart_tx #(.o(4), .depth(DEPTH)) dut4 (
        .clk(clk), .rst(rst), .in(in), .clk_in(clk_in),
        .out(out4), .full(full4), .empty(empty4), .busy(busy4)
    );

    uart_tx #(.o(5), .depth(DEPTH)) dut5 (
        .clk(clk), .rst(rst), .in(in), .clk_in(clk_in),
        .out(out5), .full(full5), .empty(empty5), .busy(busy5)
    );

    int checks = 0;
    int errors = 0;

    // Model state per instance.
    int         m_o     [2];
    int         m_cnt   [2];
    int         m_head  [2];
    int         m_t     [2];
    bit         m_frame [2];
    logic [7:0] m_cur   [2];
    logic [7:0] m_buf   [2][DEPTH];
    bit         m_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply the effect of one clock edge to the model, using current inputs.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit was_empty;
            bit was_full;
            bit pop;
            was_empty = (m_cnt[k] == 0);
            was_full  = (m_cnt[k] == DEPTH);
            pop       = 1'b0;
            if (rst) begin
                m_cnt[k]   = 0;
                m_head[k]  = 0;
                m_t[k]     = 0;
                m_frame[k] = 1'b0;
            end else begin
                if (m_frame[k]) begin
                    m_t[k]++;
                    if (m_t[k] == 10 * m_o[k]) begin
                        m_t[k] = 0;
                        if (!was_empty) pop = 1'b1;
                        else            m_frame[k] = 1'b0;
                    end
                end else if (!was_empty) begin
                    pop        = 1'b1;
                    m_frame[k] = 1'b1;
                    m_t[k]     = 0;
                end
                if (pop) begin
                    m_cur[k]  = m_buf[k][m_head[k]];
                    m_head[k] = (m_head[k] + 1) % DEPTH;
                    m_cnt[k]--;
                end
                if (clk_in && !was_full) begin
                    m_buf[k][(m_head[k] + m_cnt[k]) % DEPTH] = in;
                    m_cnt[k]++;
                end
            end
        end
        if (rst) m_valid = 1'b1;
    endtask

    // Line level from position within the frame: start, 8 data LSB first, stop.
    function automatic logic exp_out(input int k);
        int t;
        t = m_t[k];
        if (!m_frame[k])          return 1'b1;
        if (t < m_o[k])           return 1'b0;
        if (t < 9 * m_o[k])       return m_cur[k][(t - m_o[k]) / m_o[k]];
        return 1'b1;
    endfunction

    // One clock edge: advance the model, then compare every DUT output to it.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        if (m_valid) begin
            chk("out4",   32'(out4),   32'(exp_out(0)));
            chk("busy4",  32'(busy4),  32'(m_frame[0]));
            chk("empty4", 32'(empty4), 32'(m_cnt[0] == 0));
            chk("full4",  32'(full4),  32'(m_cnt[0] == DEPTH));
            chk("out5",   32'(out5),   32'(exp_out(1)));
            chk("busy5",  32'(busy5),  32'(m_frame[1]));
            chk("empty5", 32'(empty5), 32'(m_cnt[1] == 0));
            chk("full5",  32'(full5),  32'(m_cnt[1] == DEPTH));
        end
    endtask

    task automatic wait_idle(input int max_cycles);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (!busy4 && !busy5 && empty4 && empty5) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        if (!done) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic write_byte(input logic [7:0] b);
        clk_in = 1'b1;
        in     = b;
        tick();
        clk_in = 1'b0;
    endtask

    initial begin
        logic [9:0]  fr55;
        logic [19:0] fr2;
        int          nbusy;
        int          nlow;

        m_o[0] = 4;
        m_o[1] = 5;
        rst    = 1'b1;
        clk_in = 1'b0;
        in     = 8'h00;
        tick();
        tick();
        rst = 1'b0;

        // Reset state, then a quiet idle stretch.
        chk("rst_out",   32'(out4),   32'd1);
        chk("rst_empty", 32'(empty4), 32'd1);
        chk("rst_full",  32'(full4),  32'd0);
        chk("rst_busy",  32'(busy4),  32'd0);
        repeat (20) tick();
        chk("idle_out", 32'(out4), 32'd1);

        // Single 0x55 frame: literal line pattern, 4 cycles per bit.
        fr55 = {1'b1, 8'h55, 1'b0};
        write_byte(8'h55);
        for (int c = 1; c <= 41; c++) begin
            tick();
            if (c <= 40) chk("f55_line", 32'(out4), 32'(fr55[(c - 1) / 4]));
            if (c == 40) chk("f55_busy40", 32'(busy4), 32'd1);
            if (c == 41) chk("f55_busy41", 32'(busy4), 32'd0);
        end
        wait_idle(200);

        // Two back-to-back frames, no idle gap.
        fr2 = {1'b1, 8'h0F, 1'b0, 1'b1, 8'hA3, 1'b0};
        write_byte(8'hA3);
        write_byte(8'h0F);
        for (int c = 2; c <= 80; c++) begin
            tick();
            chk("f2_line", 32'(out4), 32'(fr2[(c - 1) / 4]));
        end
        wait_idle(300);

        // Overfill: 0x05 must be dropped.
        for (int i = 0; i < 6; i++) begin
            write_byte(8'(i));
            if (i == 3) chk("ovf_full3", 32'(full4), 32'd0);
            if (i >= 4) chk("ovf_full",  32'(full4), 32'd1);
        end
        wait_idle(600);

        // Reset mid-frame with two bytes still queued.
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        repeat (8) tick();
        rst    = 1'b1;
        clk_in = 1'b1;
        in     = 8'h44;
        tick();
        rst    = 1'b0;
        clk_in = 1'b0;
        chk("abort_out",   32'(out4),   32'd1);
        chk("abort_empty", 32'(empty4), 32'd1);
        chk("abort_busy",  32'(busy4),  32'd0);
        repeat (60) tick();
        chk("abort_quiet", 32'(out4 & ~busy4), 32'd1);

        // o=5, 0xFF: 5 low cycles, 50 busy cycles.
        write_byte(8'hFF);
        nbusy = 0;
        nlow  = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (busy5) nbusy++;
            if (!out5) nlow++;
        end
        chk("o5_busy_len", 32'(nbusy), 32'd50);
        chk("o5_low_len",  32'(nlow),  32'd5);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            clk_in = ($urandom_range(0, 9) < 4);
            in     = 8'($urandom);
            rst    = ($urandom_range(0, 499) == 0);
            tick();
        end
        clk_in = 1'b0;
        rst    = 1'b0;
        wait_idle(1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
